// File: rtl/cpu_phase_pkg.sv
// Phase encodings and sequencer state shared by the multi-cycle CPU control path.
// Instruction memory, decoder and writeback logic key off these constants.
package cpu_phase_pkg;

  localparam int PC_SIZE_DEFAULT = 5;

  localparam logic [1:0] PH_FETCH = 2'b00;
  localparam logic [1:0] PH_REGRD = 2'b01;
  localparam logic [1:0] PH_EXMEM = 2'b10;
  localparam logic [1:0] PH_WB    = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'b000,
    ST_DECODE = 3'b001,
    ST_EXEC   = 3'b010,
    ST_WB     = 3'b011,
    ST_HALT   = 3'b100
  } seq_state_e;

  // HALT parks on the reg-read phase so memories see neither a fetch nor a writeback.
  function automatic logic [1:0] phase_of(input seq_state_e s);
    logic [1:0] ph;
    case (s)
      ST_FETCH:  ph = PH_FETCH;
      ST_DECODE: ph = PH_REGRD;
      ST_EXEC:   ph = PH_EXMEM;
      ST_WB:     ph = PH_WB;
      default:   ph = PH_REGRD;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Program counter and four-phase sequencer for the multi-cycle CPU.
// Commits the next PC at writeback; supports stall, branch and a reset-only-exit halt.
module pc_sequencer
  import cpu_phase_pkg::*;
#(
  parameter int                 PC_SIZE  = PC_SIZE_DEFAULT,
  parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_SIZE-1:0] branch_target,
  input  logic               halt_req,
  output logic [1:0]         phase,
  output logic [PC_SIZE-1:0] pc,
  output logic [PC_SIZE-1:0] pc_plus_one,
  output logic               retire,
  output logic               halted
);

  seq_state_e         state_q, state_d;
  logic [PC_SIZE-1:0] pc_q, pc_d;
  logic [1:0]         phase_q, phase_d;
  logic               retire_q, retire_d;
  logic               halted_q, halted_d;
  logic               commit;

  assign commit = (state_q == ST_WB) && !stall;

  // State register: phase/halted/retire are registered alongside the FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      phase_q  <= PH_FETCH;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      phase_q  <= phase_d;
      retire_q <= retire_d;
      halted_q <= halted_d;
    end
  end

  // Next state; HALT is absorbing and stall freezes everything else.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (!stall) begin
      case (state_q)
        ST_FETCH:  state_d = ST_DECODE;
        ST_DECODE: state_d = ST_EXEC;
        ST_EXEC:   state_d = ST_WB;
        ST_WB:     state_d = halt_req ? ST_HALT : ST_FETCH;
        ST_HALT:   state_d = ST_HALT;
        default:   state_d = ST_FETCH;
      endcase
    end
    if (commit) begin
      pc_d = branch_taken ? branch_target : pc_plus_one;
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    phase_d  = phase_of(state_d);
    halted_d = (state_d == ST_HALT);
    retire_d = commit;
  end

  assign pc_plus_one = pc_q + PC_SIZE'(1);
  assign phase       = phase_q;
  assign pc          = pc_q;
  assign retire      = retire_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_sequencer;

  logic       clk;
  logic       reset;
  logic       stall;
  logic       branch_taken;
  logic [4:0] branch_target;
  logic       halt_req;
  logic [1:0] phase;
  logic [4:0] pc;
  logic [4:0] pc_plus_one;
  logic       retire;
  logic       halted;

  typedef struct packed {
    logic [1:0] ph;
    logic [4:0] pc;
    logic [4:0] ppo;
    logic       ret;
    logic       hlt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_step = 0;

  pc_sequencer #(
    .PC_SIZE  (5),
    .RESET_PC (5'd0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .phase         (phase),
    .pc            (pc),
    .pc_plus_one   (pc_plus_one),
    .retire        (retire),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for one clock edge, then queue the outputs expected after that edge.
  task automatic step(input logic rst, input logic stl, input logic br, input logic [4:0] tgt,
                      input logic hr, input logic [1:0] eph, input logic [4:0] epc,
                      input logic eret, input logic ehlt);
    exp_t e;
    reset         = rst;
    stall         = stl;
    branch_taken  = br;
    branch_target = tgt;
    halt_req      = hr;
    @(posedge clk);
    #1;
    e.ph  = eph;
    e.pc  = epc;
    e.ppo = epc + 5'd1;
    e.ret = eret;
    e.hlt = ehlt;
    exp_q.push_back(e);
  endtask

  // One unstalled instruction starting with FETCH already on the outputs.
  task automatic instr(input logic [4:0] cur, input logic [4:0] nxt, input logic br_wb,
                       input logic [4:0] tgt, input logic hr, input logic br_ex);
    step(1'b0, 1'b0, 1'b0,  5'd0, 1'b0, 2'b01, cur, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0,  5'd0, 1'b0, 2'b10, cur, 1'b0, 1'b0);
    step(1'b0, 1'b0, br_ex, 5'd5, 1'b0, 2'b11, cur, 1'b0, 1'b0);
    if (hr)
      step(1'b0, 1'b0, br_wb, tgt, 1'b1, 2'b01, nxt, 1'b1, 1'b1);
    else
      step(1'b0, 1'b0, br_wb, tgt, 1'b0, 2'b00, nxt, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_step++;
      n_cmp++;
      if (phase !== e.ph || pc !== e.pc || pc_plus_one !== e.ppo ||
          retire !== e.ret || halted !== e.hlt) begin
        n_bad++;
        $display("FAIL step%0d: got ph=%b pc=%0d ppo=%0d ret=%b hlt=%b, want ph=%b pc=%0d ppo=%0d ret=%b hlt=%b",
                 n_step, phase, pc, pc_plus_one, retire, halted,
                 e.ph, e.pc, e.ppo, e.ret, e.hlt);
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; halt_req = 1'b0;

    // Reset state, then 8 plain cycles covering two instructions.
    step(1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 2'b00, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
    instr(5'd0, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
    instr(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);

    // Branch up to 30, step to 31, then wrap to 0.
    instr(5'd2,  5'd30, 1'b1, 5'd30, 1'b0, 1'b0);
    instr(5'd30, 5'd31, 1'b0, 5'd0,  1'b0, 1'b0);
    instr(5'd31, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0);

    // Taken branch in WB, then a branch pulse in EXEC that must be ignored.
    instr(5'd0,  5'd17, 1'b1, 5'd17, 1'b0, 1'b0);
    instr(5'd17, 5'd18, 1'b0, 5'd0,  1'b0, 1'b1);

    // Three stall cycles in EXEC, then stall with branch held in WB.
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd18, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b10, 5'd18, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 2'b10, 5'd18, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b11, 5'd18, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 2'b11, 5'd18, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 2'b00, 5'd3, 1'b1, 1'b0);

    // Halt at pc=3: commit to 4, then parked regardless of stall/branch.
    instr(5'd3, 5'd4, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 2'b01, 5'd4, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 2'b01, 5'd4, 1'b0, 1'b1);

    // Reset out of HALT.
    step(1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0);

    // Reach pc=9, reset in EXEC: the instruction is abandoned without retire.
    instr(5'd0, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 2'b01, 5'd9, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 2'b10, 5'd9, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd12, 1'b1, 2'b00, 5'd0, 1'b0, 1'b0);
    instr(5'd0, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);

    // Self-loop branch, then normal increment.
    instr(5'd1, 5'd1, 1'b1, 5'd1, 1'b0, 1'b0);
    instr(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);

    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd2, 1'b0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Upstream control stage of the multi-cycle CPU. Owns the program counter and the 2-bit phase sequence.
- Its phase and pc outputs drive the instruction memory directly, and phase is broadcast to the register file, ALU/data memory and writeback logic.
- Advances one phase per clock, commits the next PC at writeback (sequential or branch), and supports stall and halt.

Parameters:
- PC_SIZE, 5, width of the program counter (word address into instruction memory).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  freezes phase, pc and all internal state for the cycle.
- branch_taken  input  1  sampled only in writeback phase; selects branch_target as next PC.
- branch_target  input  PC_SIZE  next PC when branch_taken=1 in writeback.
- halt_req  input  1  sampled only in writeback phase; enters HALT after the commit.
- phase  output  2  00 fetch, 01 reg read, 10 execute/mem, 11 writeback.
- pc  output  PC_SIZE  current instruction address.
- pc_plus_one  output  PC_SIZE  combinational pc+1, wrapped modulo 2^PC_SIZE (for link/branch calc).
- retire  output  1  one-cycle pulse in the cycle after a writeback commits.
- halted  output  1  high while in HALT.

Behaviour:
- Reset (sync, highest priority, overrides stall/branch/halt):
  - phase=00, pc=RESET_PC, retire=0, halted=0, FSM=FETCH.
  - Reset asserted mid-instruction abandons it; no commit, no retire.
- FSM states FETCH(00) -> DECODE(01) -> EXEC(10) -> WB(11) -> FETCH, plus HALT. The phase output equals the state encoding.
- One transition per clock when stall=0.
- stall=1 in any non-HALT state:
  - state, pc and halted hold.
  - retire is 0 that cycle.
  - Stall may last any number of cycles.
- WB with stall=0 (commit):
  - pc <= branch_taken ? branch_target : pc+1.
  - Increment wraps: 2^PC_SIZE-1 -> 0.
  - retire=1 in the following cycle only.
  - If halt_req=1 in the same cycle, the next state is HALT, otherwise FETCH. The pc update still occurs.
- branch_taken and halt_req are ignored outside WB and ignored during stall.
- HALT:
  - phase output held at 01 (no fetch, no writeback side effects).
  - halted=1, pc frozen.
  - stall has no effect. Exit only via reset.
- Latency:
  - Instruction memory registers instr on the posedge ending phase 00, so instr is valid throughout phases 01–11 for the current pc.
  - A new pc is visible from the first cycle of the next FETCH.
  - One instruction every 4 cycles when unstalled.
- branch_target equal to the current pc is legal: a self-loop.
- Outputs are registered except pc_plus_one.

Decomposition:
- Shared package cpu_phase_pkg:
  - phase constants PH_FETCH=2'b00, PH_REGRD=2'b01, PH_EXMEM=2'b10, PH_WB=2'b11.
  - PC_SIZE default, reused by instruction_memory and the decoder.
- Single module; no sub-module needed. The FSM and PC register are small and tightly coupled.

Test Plan:
- Reset then 8 unstalled cycles -> phase sequence 00,01,10,11,00,01,10,11; pc 0 for cycles 0–3, 1 for 4–7; retire high only at cycle 4.
- pc=31 (PC_SIZE=5) through WB with branch_taken=0 -> pc=0 at next FETCH; pc_plus_one=0 while pc=31.
- Branch: in WB assert branch_taken=1, branch_target=5'd17 -> next FETCH pc=17. Branch_taken=1 pulsed in phase 10 only -> ignored, pc increments.
- Stall: assert stall 3 cycles during phase 10 -> phase stays 10 for 4 total cycles, pc unchanged, retire 0. Stall+branch_taken in WB -> no commit until stall drops.
- Halt: halt_req=1 in WB at pc=3 with branch_taken=0 -> pc=4, retire pulse, then phase=01, halted=1 indefinitely, unaffected by stall or branch inputs.
- Reset mid-instruction (phase 10, pc=9) and reset during HALT -> next cycle phase=00, pc=RESET_PC, halted=0, retire=0.
